// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD-to-binary conversion blocks.
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } bcd_state_e;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] DABBLE_ADJ    = 4'd3;

  // Ceiling log2 with a floor of 1 bit, used to size iteration counters.
  function automatic int unsigned clog2(input longint unsigned value);
    int unsigned width;
    width = 1;
    while ((width < 63) && ((64'd1 << width) < value)) begin
      width++;
    end
    return width;
  endfunction

  // Largest value representable by the given number of BCD digits (10^digits - 1).
  function automatic longint unsigned bcd_max_value(input int unsigned digits);
    longint unsigned acc;
    acc = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      acc = acc * 64'd10;
    end
    return acc - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: subtract 3 from a nibble that is 8 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Nibble arithmetic only; a borrow never leaves the digit.
  assign digit_o = digit_i[3] ? (digit_i - DABBLE_ADJ) : digit_i;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one shift per clock,
// with valid/ready handshakes on both sides.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int unsigned WorkW = 4 * DIGITS + BIN_W;
  localparam int unsigned CntW  = clog2(longint'(BIN_W) + 1);

  if ((DIGITS < 1) || (DIGITS > 19)) begin : g_bad_digits
    $fatal(1, "bcd2bin_seq: DIGITS must be in 1..19");
  end

  if ((BIN_W < 64) && ((64'd1 << BIN_W) <= bcd_max_value(DIGITS))) begin : g_bad_width
    $fatal(1, "bcd2bin_seq: BIN_W too narrow for 10^DIGITS-1");
  end

  bcd_state_e         state_q, state_d;
  logic [WorkW-1:0]   work_q, work_d;
  logic [WorkW-1:0]   work_shift, work_adj;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               err_q, err_d;
  logic               bad_digit;
  logic               last_iter;

  // Any nibble above 9 short-circuits the conversion into an error result.
  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > BCD_MAX_DIGIT) begin
        bad_digit = 1'b1;
      end
    end
  end

  assign work_shift = work_q >> 1;
  assign work_adj[BIN_W-1:0] = work_shift[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (work_shift[BIN_W + 4*g +: 4]),
      .digit_o (work_adj[BIN_W + 4*g +: 4])
    );
  end

  assign last_iter = (cnt_q == CntW'(BIN_W - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = bad_digit ? StDone : StShift;
      StShift: if (last_iter) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  // Datapath next-state
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    bin_d  = bin_q;
    err_d  = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (bad_digit) begin
            bin_d = '0;
            err_d = 1'b1;
          end else begin
            work_d = {bcd_in, {BIN_W{1'b0}}};
            cnt_d  = '0;
          end
        end
      end
      StShift: begin
        work_d = work_adj;
        cnt_d  = cnt_q + CntW'(1);
        if (last_iter) begin
          bin_d = work_adj[BIN_W-1:0];
          err_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
      cnt_q  <= '0;
      bin_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      bin_q  <= bin_d;
      err_q  <= err_d;
    end
  end

  assign bin_out = bin_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed and randomized checks of bcd2bin_seq at 3 and 4 digits against a decimal model.
module tb_bcd2bin_seq;

  logic        clk;
  logic        rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err;
  logic [11:0] a_bcd_in;
  logic [9:0]  a_bin_out;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err;
  logic [15:0] b_bcd_in;
  logic [13:0] b_bin_out;

  int n_assert = 0;
  int n_fail   = 0;

  bcd2bin_seq #(.DIGITS(3), .BIN_W(10)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .bcd_in    (a_bcd_in),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .bin_out   (a_bin_out),
    .err       (a_err)
  );

  bcd2bin_seq #(.DIGITS(4), .BIN_W(14)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .bcd_in    (b_bcd_in),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .bin_out   (b_bin_out),
    .err       (b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Decimal value of the digits, most significant first; any digit over 9 flags an error.
  function automatic void ref_model(input logic [63:0] bcd, input int digits,
                                    output logic [63:0] val, output logic bad);
    logic [3:0] d;
    val = 0;
    bad = 1'b0;
    for (int i = digits - 1; i >= 0; i--) begin
      d = bcd[4*i +: 4];
      if (d > 4'd9) bad = 1'b1;
      val = val * 10 + 64'(d);
    end
    if (bad) val = 0;
  endfunction

  function automatic logic [63:0] rand_bcd(input int digits);
    logic [63:0] v;
    v = 0;
    for (int i = 0; i < digits; i++) begin
      if ($urandom_range(0, 15) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else                            v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  task automatic run_a(input logic [11:0] bcd, input int hold);
    logic [63:0] exp_v;
    logic        exp_e;
    int          cycles;
    ref_model(64'(bcd), 3, exp_v, exp_e);
    a_in_valid  = 1'b1;
    a_bcd_in    = bcd;
    a_out_ready = (hold == 0);
    chk("a_in_ready_idle", 64'(a_in_ready), 1);
    @(posedge clk); @(negedge clk);
    a_in_valid = 1'b0;
    a_bcd_in   = 12'($urandom);
    cycles = 0;
    while (!a_out_valid && cycles < 40) begin
      chk("a_in_ready_busy", 64'(a_in_ready), 0);
      @(posedge clk); @(negedge clk);
      cycles++;
    end
    chk("a_out_valid", 64'(a_out_valid), 1);
    if (!exp_e) chk("a_latency", 64'(cycles), 10);
    chk("a_bin_out", 64'(a_bin_out), exp_v);
    chk("a_err", 64'(a_err), 64'(exp_e));
    chk("a_in_ready_done", 64'(a_in_ready), 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      chk("a_hold_valid", 64'(a_out_valid), 1);
      chk("a_hold_bin", 64'(a_bin_out), exp_v);
      chk("a_hold_err", 64'(a_err), 64'(exp_e));
    end
    a_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    a_out_ready = 1'b0;
    chk("a_out_valid_after", 64'(a_out_valid), 0);
    chk("a_in_ready_after", 64'(a_in_ready), 1);
  endtask

  task automatic run_b(input logic [15:0] bcd, input int hold);
    logic [63:0] exp_v;
    logic        exp_e;
    int          cycles;
    ref_model(64'(bcd), 4, exp_v, exp_e);
    b_in_valid  = 1'b1;
    b_bcd_in    = bcd;
    b_out_ready = (hold == 0);
    chk("b_in_ready_idle", 64'(b_in_ready), 1);
    @(posedge clk); @(negedge clk);
    b_in_valid = 1'b0;
    b_bcd_in   = 16'($urandom);
    cycles = 0;
    while (!b_out_valid && cycles < 40) begin
      @(posedge clk); @(negedge clk);
      cycles++;
    end
    chk("b_out_valid", 64'(b_out_valid), 1);
    if (!exp_e) chk("b_latency", 64'(cycles), 14);
    chk("b_bin_out", 64'(b_bin_out), exp_v);
    chk("b_err", 64'(b_err), 64'(exp_e));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      chk("b_hold_bin", 64'(b_bin_out), exp_v);
    end
    b_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    b_out_ready = 1'b0;
    chk("b_in_ready_after", 64'(b_in_ready), 1);
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_bcd_in = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_bcd_in = '0; b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 64'(a_in_ready), 1);
    chk("rst_out_valid", 64'(a_out_valid), 0);
    chk("rst_bin_out", 64'(a_bin_out), 0);
    chk("rst_err", 64'(a_err), 0);
    chk("rst_b_in_ready", 64'(b_in_ready), 1);

    run_a(12'h255, 0);
    run_a(12'h999, 0);
    run_a(12'h000, 0);
    run_a(12'h1A3, 0);
    run_a(12'h042, 0);
    run_a(12'h507, 20);

    // Reset lands on the edge that would perform iteration 5.
    a_in_valid = 1'b1;
    a_bcd_in   = 12'h888;
    @(posedge clk); @(negedge clk);
    a_in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      chk("midrst_no_valid", 64'(a_out_valid), 0);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 64'(a_in_ready), 1);
    chk("midrst_out_valid", 64'(a_out_valid), 0);
    chk("midrst_bin_out", 64'(a_bin_out), 0);
    chk("midrst_err", 64'(a_err), 0);
    run_a(12'h123, 0);

    for (int n = 0; n < 60; n++) begin
      run_a(12'(rand_bcd(3)), $urandom_range(0, 3));
    end

    run_b(16'h0000, 0);
    run_b(16'h9999, 2);
    run_b(16'h9F99, 1);
    for (int n = 0; n < 250; n++) begin
      run_b(16'(rand_bcd(4)), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
